// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
// Memory-mapped I/O controller sitting between the processor data-memory port
// and the data RAM. Three addresses are decoded as I/O registers (debounced
// button, slide switches, LED output); every other address goes to RAM. Loads
// from I/O are registered so they show the same one-cycle latency as the RAM.
//
// Ports:
//   i_clk        system clock, all state changes on posedge
//   i_rst        asynchronous active-high reset
//   i_wren       processor store enable
//   i_addr       processor data address (12 bits)
//   i_data_in    processor store data (32 bits)
//   o_q_out      load data returned to the processor (32 bits)
//   o_ram_wren   RAM write enable (suppressed for I/O addresses)
//   i_ram_q      RAM read data, registered inside the RAM
//   i_btn_raw    raw asynchronous pushbutton
//   i_sw         raw asynchronous slide switches (16 bits)
//   o_led        LED drive (16 bits)
// -----------------------------------------------------------------------------
module mmio_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter logic [11:0] ADDR_BTN        = 12'd7,
   parameter logic [11:0] ADDR_SW         = 12'd8,
   parameter logic [11:0] ADDR_LED        = 12'd9
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wren,
   input  logic [11:0] i_addr,
   input  logic [31:0] i_data_in,
   output logic [31:0] o_q_out,
   output logic        o_ram_wren,
   input  logic [31:0] i_ram_q,
   input  logic        i_btn_raw,
   input  logic [15:0] i_sw,
   output logic [15:0] o_led
);

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } state_t;

   // Value the counter reaches on the cycle that completes the debounce window.
   localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_CYCLES - 1);

   // Synchronizers
   logic        r_btn_meta;
   logic        r_btn_s;
   logic [15:0] r_sw_meta;
   logic [15:0] r_sw_s;

   // Debounce state
   state_t      r_state;
   logic [31:0] r_cnt;
   logic        r_press_flag;

   // I/O registers and load path
   logic [15:0] r_led;
   logic [2:0]  r_sel_q;
   logic [31:0] r_io_q;

   logic        w_hit_btn;
   logic        w_hit_sw;
   logic        w_hit_led;
   logic        w_io_hit;
   logic        w_btn_level;
   logic [31:0] w_cnt_inc;
   logic        w_press_set;
   logic        w_press_clr;
   logic [31:0] w_io_rdata;
   logic        w_unused_data;

   assign w_hit_btn = (i_addr == ADDR_BTN);
   assign w_hit_sw  = (i_addr == ADDR_SW);
   assign w_hit_led = (i_addr == ADDR_LED);
   assign w_io_hit  = w_hit_btn | w_hit_sw | w_hit_led;

   assign o_ram_wren = i_wren & ~w_io_hit;

   // Upper store-data bits have no destination in the I/O map.
   assign w_unused_data = ^i_data_in[31:16];

   assign w_btn_level = (r_state == ST_HIGH) || (r_state == ST_WAIT_LOW);

   // The counter is compared after incrementing, so the cycle that enters a
   // WAIT state plus DEBOUNCE_CYCLES-1 further stable cycles make up the
   // full window of DEBOUNCE_CYCLES stable samples.
   assign w_cnt_inc   = r_cnt + 32'd1;
   assign w_press_set = (r_state == ST_WAIT_HIGH) && r_btn_s && (w_cnt_inc == CNT_LAST);
   assign w_press_clr = ~i_wren && w_hit_btn;

   // Pre-edge value of the addressed I/O register.
   always_comb begin
      w_io_rdata = 32'd0;
      if (w_hit_btn) begin
         w_io_rdata = {30'd0, w_btn_level, r_press_flag};
      end else if (w_hit_sw) begin
         w_io_rdata = {16'd0, r_sw_s};
      end else if (w_hit_led) begin
         w_io_rdata = {16'd0, r_led};
      end
   end

   // Two-flop synchronizers; the switch register is simply the second stage.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_btn_meta <= 1'b0;
         r_btn_s    <= 1'b0;
         r_sw_meta  <= 16'd0;
         r_sw_s     <= 16'd0;
      end else begin
         r_btn_meta <= i_btn_raw;
         r_btn_s    <= r_btn_meta;
         r_sw_meta  <= i_sw;
         r_sw_s     <= r_sw_meta;
      end
   end

   // Debounce FSM plus the clear-on-read press flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_LOW;
         r_cnt        <= 32'd0;
         r_press_flag <= 1'b0;
      end else begin
         case (r_state)
            ST_LOW: begin
               if (r_btn_s) begin
                  r_state <= ST_WAIT_HIGH;
                  r_cnt   <= 32'd0;
               end
            end
            ST_WAIT_HIGH: begin
               if (!r_btn_s) begin
                  r_state <= ST_LOW;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CNT_LAST) begin
                     r_state <= ST_HIGH;
                  end
               end
            end
            ST_HIGH: begin
               if (!r_btn_s) begin
                  r_state <= ST_WAIT_LOW;
                  r_cnt   <= 32'd0;
               end
            end
            ST_WAIT_LOW: begin
               if (r_btn_s) begin
                  r_state <= ST_HIGH;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CNT_LAST) begin
                     r_state <= ST_LOW;
                  end
               end
            end
            default: begin
               r_state <= ST_LOW;
            end
         endcase

         // A press completing on the same edge as a read keeps the flag set,
         // so the event is reported by the next read rather than lost.
         if (w_press_set) begin
            r_press_flag <= 1'b1;
         end else if (w_press_clr) begin
            r_press_flag <= 1'b0;
         end
      end
   end

   // LED store register; stores to the button and switch addresses are dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_led <= 16'd0;
      end else if (i_wren && w_hit_led) begin
         r_led <= i_data_in[15:0];
      end
   end

   // Load path: capture the select and I/O data so they line up with ram_q.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sel_q <= 3'd0;
         r_io_q  <= 32'd0;
      end else begin
         r_sel_q <= {w_hit_btn, w_hit_sw, w_hit_led};
         r_io_q  <= w_io_rdata;
      end
   end

   assign o_q_out = (|r_sel_q) ? r_io_q : i_ram_q;
   assign o_led   = r_led;

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller between the processor's data-memory port and the data RAM. It decodes the 12-bit data address and steers stores and loads either to RAM or to three I/O registers: a debounced, edge-captured button, the slide switches, and an LED output register. Loads keep the RAM's one-cycle read latency, so the processor sees I/O and RAM with identical timing.

## Interface
- DEBOUNCE_CYCLES, 500000 — consecutive stable samples required to accept a button level change (10 ms at 50 MHz)
- ADDR_BTN, 12'd7 — button status register address
- ADDR_SW, 12'd8 — switch register address (read-only)
- ADDR_LED, 12'd9 — LED register address (read/write)

- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- wren  in  1  processor store enable
- addr  in  12  processor data address
- data_in  in  32  processor store data
- q_out  out  32  load data returned to processor
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM read data (registered inside RAM, 1-cycle latency)
- btn_raw  in  1  raw, asynchronous pushbutton
- sw  in  16  raw, asynchronous slide switches
- led  out  16  LED drive

## Operation
- io_hit = addr ∈ {ADDR_BTN, ADDR_SW, ADDR_LED}. ram_wren = wren & ~io_hit (combinational). I/O addresses never write RAM.
- Stores: wren & addr==ADDR_LED → led <= data_in[15:0] at the edge. Stores to ADDR_BTN and ADDR_SW are ignored.
- Synchronizers: btn_raw and sw each pass through a 2-flop synchronizer. The switch register is the second-stage flop, with no debounce.
- Debounce FSM on btn_s (synchronized button), 32-bit counter cnt:
  - LOW: btn_s=1 → WAIT_HIGH, cnt<=0.
  - WAIT_HIGH: btn_s=0 → LOW. Otherwise cnt increments; when cnt == DEBOUNCE_CYCLES-1 → HIGH and press_flag<=1.
  - HIGH: btn_s=0 → WAIT_LOW, cnt<=0.
  - WAIT_LOW: btn_s=1 → HIGH. Otherwise cnt increments; when cnt == DEBOUNCE_CYCLES-1 → LOW.
  - btn_level = 1 in HIGH and WAIT_LOW, 0 otherwise.
- Button register read value = {30'b0, btn_level, press_flag}.
- Clear-on-read: the edge with wren=0 and addr==ADDR_BTN clears press_flag. If a set occurs in the same cycle, the set wins and the flag stays 1.
- Loads: at each edge, sel_q <= {addr==ADDR_BTN, addr==ADDR_SW, addr==ADDR_LED}, and io_q snapshots the addressed register's pre-edge value. q_out = |sel_q ? io_q : ram_q.
  - SW reads as {16'b0, sw_sync}.
  - LED reads as {16'b0, led}.

## Timing
- Reset values: led=0, press_flag=0, FSM=LOW, cnt=0, sel_q=0, io_q=0, synchronizer flops=0. After reset q_out follows ram_q.
- Load latency: 1 cycle. Data for the address presented before edge N appears on q_out after edge N, aligned with ram_q.
- Store latency: LED changes at the edge where the write is presented.
- Press latency from btn_raw rising: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles to press_flag=1.
- A glitch shorter than DEBOUNCE_CYCLES returns the FSM to its prior stable state and sets no flag.
- Reset asserted mid-debounce or mid-read aborts immediately; no flag is retained.
- Back-to-back reads of ADDR_BTN: the first returns bit0=1 and clears the flag; the second returns bit0=0 unless a new press completed in between.

## Test plan
- Reset, then store 32'h0000_A5A5 to addr 9 and load addr 9 → led=16'hA5A5 after the store edge; q_out=32'h0000_A5A5 one cycle after the load; ram_wren stays 0 throughout.
- Store 32'h1234 to addr 20, then load addr 20 → ram_wren=1 for that cycle; q_out equals ram_q (32'h1234 from the RAM model).
- DEBOUNCE_CYCLES=4: hold btn_raw=1 for 10 cycles → press_flag=1 exactly 6 cycles after the rise. Load addr 7 → 32'h3, then load addr 7 again → 32'h2.
- DEBOUNCE_CYCLES=4: 3-cycle pulse on btn_raw → load addr 7 returns 32'h0; FSM back in LOW.
- sw=16'hBEEF, then load addr 8 → q_out=32'h0000_BEEF. Store to addr 8 → ram_wren=0 and no state change.
- Assert reset mid-WAIT_HIGH and after an LED write → led=0, press_flag=0, FSM=LOW, q_out tracks ram_q.
